// File: rtl/mtimer.sv
// rtl/mtimer.sv - memory-mapped 64-bit machine timer with prescaler, compare and level interrupt
`default_nettype none

module mtimer #(
   parameter int          PRESC_W   = 8,
   parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tmr_sel,
   input  logic        tmr_wr,
   input  logic        tmr_rd,
   input  logic [31:0] tmr_addr32,
   input  logic [31:0] tmr_wdata,
   output logic [31:0] tmr_rdata,
   output logic        tmr_rvalid,
   output logic        timer_irq
);

   // Word offsets within the block
   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_STATUS   = 3'd5;

   // Architectural state
   logic [63:0]        mtime;
   logic [63:0]        mtimecmp;
   logic               en;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;
   logic [31:0]        hi_shadow;

   // Bus decode
   logic [2:0]  idx;
   logic        wr_acc;
   logic        rd_acc;
   logic        wr_mtime_lo;
   logic        wr_mtime_hi;
   logic        wr_cmp_lo;
   logic        wr_cmp_hi;
   logic        wr_ctrl;
   logic        rd_mtime_lo;
   logic        tick;
   logic        cmp_hit;
   logic [31:0] ctrl_view;
   logic [31:0] rd_mux;

   // Only addr[4:2] select a register; the rest of the address is don't-care
   logic unused_addr_bits;
   assign unused_addr_bits = ^{tmr_addr32[31:5], tmr_addr32[1:0]};

   assign idx    = tmr_addr32[4:2];
   assign wr_acc = tmr_sel & tmr_wr;
   assign rd_acc = tmr_sel & tmr_rd;

   assign wr_mtime_lo = wr_acc & (idx == A_MTIME_LO);
   assign wr_mtime_hi = wr_acc & (idx == A_MTIME_HI);
   assign wr_cmp_lo   = wr_acc & (idx == A_CMP_LO);
   assign wr_cmp_hi   = wr_acc & (idx == A_CMP_HI);
   assign wr_ctrl     = wr_acc & (idx == A_CTRL);
   assign rd_mtime_lo = rd_acc & (idx == A_MTIME_LO);

   // A tick is the last cycle of a prescale period while counting is enabled
   assign tick    = en & (presc_cnt == presc);
   assign cmp_hit = (mtime >= mtimecmp);

   // CTRL readback: EN in bit 0, PRESC in its field, everything else zero
   always_comb begin
      ctrl_view                = '0;
      ctrl_view[0]             = en;
      ctrl_view[8 +: PRESC_W]  = presc;
   end

   // Read data selection uses pre-edge values, so a same-cycle write is not visible
   always_comb begin
      rd_mux = '0;
      case (idx)
         A_MTIME_LO: rd_mux = mtime[31:0];
         A_MTIME_HI: rd_mux = hi_shadow;
         A_CMP_LO:   rd_mux = mtimecmp[31:0];
         A_CMP_HI:   rd_mux = mtimecmp[63:32];
         A_CTRL:     rd_mux = ctrl_view;
         A_STATUS:   rd_mux = {31'd0, timer_irq};
         default:    rd_mux = '0;
      endcase
   end

   // Control register: enable and prescale divisor
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en    <= 1'b0;
         presc <= '0;
      end else if (wr_ctrl) begin
         en    <= tmr_wdata[0];
         presc <= tmr_wdata[8 +: PRESC_W];
      end
   end

   // Prescale counter: restarts on any CTRL write, parked at 0 while disabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_cnt <= '0;
      end else if (wr_ctrl || !en || tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

   // mtime: a software write to either half wins over a coincident tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime <= '0;
      end else if (wr_mtime_lo) begin
         mtime[31:0] <= tmr_wdata;
      end else if (wr_mtime_hi) begin
         mtime[63:32] <= tmr_wdata;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp: halves are written independently, no atomic update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtimecmp <= RESET_CMP;
      end else if (wr_cmp_lo) begin
         mtimecmp[31:0] <= tmr_wdata;
      end else if (wr_cmp_hi) begin
         mtimecmp[63:32] <= tmr_wdata;
      end
   end

   // Hi shadow: captured alongside a LO read so LO-then-HI forms one snapshot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_shadow <= '0;
      end else if (rd_mtime_lo) begin
         hi_shadow <= mtime[63:32];
      end
   end

   // Read response: one-cycle valid pulse, data holds after the pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr_rvalid <= 1'b0;
         tmr_rdata  <= '0;
      end else begin
         tmr_rvalid <= rd_acc;
         if (rd_acc) begin
            tmr_rdata <= rd_mux;
         end
      end
   end

   // Interrupt level registered from the pre-edge compare result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= en & cmp_hit;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mtimer.sv
// tb/tb_mtimer.sv - directed self-checking bench for mtimer
`timescale 1ns/1ps

module tb_mtimer;

   logic        clk;
   logic        rst;
   logic        tmr_sel;
   logic        tmr_wr;
   logic        tmr_rd;
   logic [31:0] tmr_addr32;
   logic [31:0] tmr_wdata;
   logic [31:0] tmr_rdata;
   logic        tmr_rvalid;
   logic        timer_irq;

   int checks;
   int errors;

   mtimer #(.PRESC_W(8), .RESET_CMP(64'hFFFF_FFFF_FFFF_FFFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .tmr_sel    (tmr_sel),
      .tmr_wr     (tmr_wr),
      .tmr_rd     (tmr_rd),
      .tmr_addr32 (tmr_addr32),
      .tmr_wdata  (tmr_wdata),
      .tmr_rdata  (tmr_rdata),
      .tmr_rvalid (tmr_rvalid),
      .timer_irq  (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [2:0] MLO = 3'd0, MHI = 3'd1, CLO = 3'd2, CHI = 3'd3, CTL = 3'd4, STS = 3'd5;

   typedef struct {
      string       name;
      logic        is_wr;
      logic [2:0]  idx;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] mk_addr(input logic [2:0] idx);
      return {27'h2A5A5A5, idx, 2'b01};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // All bus tasks start and end just after a falling edge
   task automatic do_write(input logic [2:0] idx, input logic [31:0] data);
      tmr_sel = 1'b1; tmr_wr = 1'b1; tmr_addr32 = mk_addr(idx); tmr_wdata = data;
      @(negedge clk);
      tmr_sel = 1'b0; tmr_wr = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] idx, output logic [31:0] data);
      tmr_sel = 1'b1; tmr_rd = 1'b1; tmr_addr32 = mk_addr(idx);
      @(negedge clk);
      tmr_sel = 1'b0; tmr_rd = 1'b0;
      check("rvalid_pulse", {31'd0, tmr_rvalid}, 32'd1);
      data = tmr_rdata;
   endtask

   task automatic read_expect(input string name, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] d;
      do_read(idx, d);
      check(name, d, exp);
   endtask

   logic [31:0] rd;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0; tmr_sel = 1'b0; tmr_wr = 1'b0; tmr_rd = 1'b0;
      tmr_addr32 = '0; tmr_wdata = '0;
      repeat (2) @(negedge clk);
      check("reset_rdata", tmr_rdata, 32'd0);
      check("reset_rvalid", {31'd0, tmr_rvalid}, 32'd0);
      check("reset_irq", {31'd0, timer_irq}, 32'd0);
      rst = 1'b1;

      // Register access table, timer disabled so state is static
      vecs.push_back('{"rst_cmp_lo",   1'b0, CLO, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{"rst_cmp_hi",   1'b0, CHI, 32'h0, 32'hFFFF_FFFF});
      vecs.push_back('{"rst_ctrl",     1'b0, CTL, 32'h0, 32'h0000_0000});
      vecs.push_back('{"rst_mtime_lo", 1'b0, MLO, 32'h0, 32'h0000_0000});
      vecs.push_back('{"rst_status",   1'b0, STS, 32'h0, 32'h0000_0000});
      vecs.push_back('{"wr_ctrl",      1'b1, CTL, 32'hFFFF_FFFE, 32'h0});
      vecs.push_back('{"ctrl_mask",    1'b0, CTL, 32'h0, 32'h0000_FF00});
      vecs.push_back('{"wr_cmp_hi",    1'b1, CHI, 32'h1234_5678, 32'h0});
      vecs.push_back('{"cmp_hi_rb",    1'b0, CHI, 32'h0, 32'h1234_5678});
      vecs.push_back('{"wr_unmapped6", 1'b1, 3'd6, 32'hDEAD_BEEF, 32'h0});
      vecs.push_back('{"unmapped6",    1'b0, 3'd6, 32'h0, 32'h0});
      vecs.push_back('{"unmapped7",    1'b0, 3'd7, 32'h0, 32'h0});
      vecs.push_back('{"wr_mtime_hi",  1'b1, MHI, 32'hCAFE_0000, 32'h0});
      vecs.push_back('{"lo_snap",      1'b0, MLO, 32'h0, 32'h0});
      vecs.push_back('{"hi_snap",      1'b0, MHI, 32'h0, 32'hCAFE_0000});
      vecs.push_back('{"wr_mtime_hi0", 1'b1, MHI, 32'h0, 32'h0});
      vecs.push_back('{"hi_is_shadow", 1'b0, MHI, 32'h0, 32'hCAFE_0000});
      vecs.push_back('{"wr_ctrl0",     1'b1, CTL, 32'h0, 32'h0});
      vecs.push_back('{"wr_cmp_hi_f",  1'b1, CHI, 32'hFFFF_FFFF, 32'h0});
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_wr) do_write(vecs[i].idx, vecs[i].wdata);
         else               read_expect(vecs[i].name, vecs[i].idx, vecs[i].exp);
      end

      // rvalid is a single pulse and rdata holds afterwards
      read_expect("pre_hold", CLO, 32'hFFFF_FFFF);
      @(negedge clk);
      check("rvalid_drop", {31'd0, tmr_rvalid}, 32'd0);
      check("rdata_hold", tmr_rdata, 32'hFFFF_FFFF);

      // Free run, PRESC=0: ten ticks after enabling
      do_write(CTL, 32'h0000_0001);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("irq_low_freerun", {31'd0, timer_irq}, 32'd0);
      end
      read_expect("freerun_lo", MLO, 32'd10);

      // Prescaler PRESC=3: one tick per four cycles
      do_write(CTL, 32'h0);
      do_write(MLO, 32'h0);
      do_write(MHI, 32'h0);
      do_write(CTL, 32'h0000_0301);
      repeat (40) @(negedge clk);
      read_expect("presc_40cyc", MLO, 32'd10);
      @(negedge clk);
      do_write(CTL, 32'h0000_0301);
      repeat (3) @(negedge clk);
      read_expect("presc_restart_a", MLO, 32'd10);
      read_expect("presc_restart_b", MLO, 32'd11);

      // Compare at 20: irq rises one cycle after mtime reaches 20
      do_write(CTL, 32'h0);
      do_write(MLO, 32'h0);
      do_write(MHI, 32'h0);
      do_write(CHI, 32'h0);
      do_write(CLO, 32'd20);
      do_write(CTL, 32'h0000_0001);
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         check($sformatf("irq_edge_%0d", k), {31'd0, timer_irq}, {31'd0, (k >= 21)});
      end
      read_expect("status_irq", STS, 32'd1);
      do_write(CLO, 32'hFFFF_FFFF);
      @(negedge clk);
      check("irq_fall", {31'd0, timer_irq}, 32'd0);

      // Carry across the 32-bit boundary with LO/HI snapshot
      do_write(CTL, 32'h0);
      do_write(MHI, 32'h0);
      do_write(MLO, 32'hFFFF_FFFE);
      do_write(CTL, 32'h0000_0001);
      @(negedge clk);
      read_expect("carry_lo_a", MLO, 32'hFFFF_FFFF);
      read_expect("carry_hi_a", MHI, 32'h0);
      read_expect("carry_lo_b", MLO, 32'h1);
      read_expect("carry_hi_b", MHI, 32'h1);

      // 64-bit wrap to zero
      do_write(CTL, 32'h0);
      do_write(MLO, 32'hFFFF_FFFF);
      do_write(MHI, 32'hFFFF_FFFF);
      do_write(CTL, 32'h0000_0001);
      @(negedge clk);
      read_expect("wrap_lo", MLO, 32'h0);
      read_expect("wrap_hi", MHI, 32'h0);

      // Write on a tick cycle wins over the increment
      do_write(MLO, 32'd5);
      read_expect("wr_prio_lo", MLO, 32'd5);

      // Simultaneous read and write: read sees the old value
      tmr_sel = 1'b1; tmr_rd = 1'b1; tmr_wr = 1'b1; tmr_addr32 = mk_addr(CLO); tmr_wdata = 32'h0000_1234;
      @(negedge clk);
      tmr_sel = 1'b0; tmr_rd = 1'b0; tmr_wr = 1'b0;
      check("rw_old_value", tmr_rdata, 32'hFFFF_FFFF);
      read_expect("rw_new_value", CLO, 32'h0000_1234);

      // Asynchronous reset while irq is high and a read is in flight
      do_write(CHI, 32'h0);
      do_write(CLO, 32'h0);
      repeat (2) @(negedge clk);
      check("irq_before_rst", {31'd0, timer_irq}, 32'd1);
      tmr_sel = 1'b1; tmr_rd = 1'b1; tmr_addr32 = mk_addr(CTL);
      @(posedge clk);
      #2;
      check("rvalid_before_rst", {31'd0, tmr_rvalid}, 32'd1);
      check("rdata_before_rst", tmr_rdata, 32'd1);
      #1;
      rst = 1'b0;
      tmr_sel = 1'b0; tmr_rd = 1'b0;
      #1;
      check("rst_async_irq", {31'd0, timer_irq}, 32'd0);
      check("rst_async_rvalid", {31'd0, tmr_rvalid}, 32'd0);
      check("rst_async_rdata", tmr_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      read_expect("post_rst_cmp_lo", CLO, 32'hFFFF_FFFF);
      read_expect("post_rst_cmp_hi", CHI, 32'hFFFF_FFFF);
      read_expect("post_rst_ctrl", CTL, 32'h0);
      check("post_rst_irq", {31'd0, timer_irq}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mtimer.md
# mtimer

Memory-mapped machine timer that generates the level-sensitive timer interrupt consumed by the core's CSR unit as its `interrupt` input. It drives the MIP.MTIP source. It holds a 64-bit free-running `mtime` with a programmable prescaler and a 64-bit `mtimecmp`. Both are accessible over a 32-bit word bus from the load/store path. `timer_irq` asserts while `mtime >= mtimecmp` and the timer is enabled.

## Interface
- PRESC_W, 8, width of the prescale field and of the prescale counter.
- RESET_CMP, 64'hFFFF_FFFF_FFFF_FFFF, reset value of `mtimecmp`; chosen so no interrupt fires out of reset.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- tmr_sel  in  1  block select from the address decoder.
- tmr_wr  in  1  write strobe; qualified by `tmr_sel`.
- tmr_rd  in  1  read strobe; qualified by `tmr_sel`.
- tmr_addr32  in  32  byte address; only `[4:2]` are decoded.
- tmr_wdata  in  32  write data.
- tmr_rdata  out  32  read data; valid while `tmr_rvalid` is high.
- tmr_rvalid  out  1  single-cycle pulse, one cycle after an accepted read.
- timer_irq  out  1  registered timer interrupt, level.

## Operation
- Register map, word offset `addr[4:2]`:
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 EN; bits[8+PRESC_W-1:8] PRESC; other bits read 0
  - 5 STATUS: bit0 = `timer_irq`; read-only
  - 6–7 unmapped: read 0, writes ignored.
- Reset values: `mtime`=0, `mtimecmp`=RESET_CMP, CTRL=0, prescale count=0, hi shadow=0, `tmr_rdata`=0, `tmr_rvalid`=0, `timer_irq`=0.
- Prescaler, EN=1:
  - The prescale count runs 0..PRESC.
  - On the cycle count==PRESC, the count returns to 0 and `mtime` increments by 1 (a "tick").
  - PRESC=0 gives one tick every cycle; PRESC=N gives one tick every N+1 cycles.
- EN=0: prescale count is held at 0 and `mtime` is held.
- Any write to CTRL clears the prescale count to 0.
- Arithmetic: `mtime` is a 64-bit unsigned value and wraps from 2^64-1 to 0 with no flag. The compare `mtime >= mtimecmp` is 64-bit unsigned.
- Write to MTIME_LO/HI: replaces that 32-bit half. No increment is applied to `mtime` that cycle, even if a tick coincides; the prescale count still advances.
- Write to MTIMECMP_LO/HI: replaces that half.
  - Each half is written independently; there is no atomic 64-bit update.
  - Firmware writes MTIMECMP_HI=FFFF_FFFF first to avoid a spurious interrupt. Hardware does not enforce this.
- Hi shadow:
  - An accepted read of MTIME_LO returns the live lo half and latches the live hi half into the shadow at the same edge.
  - A read of MTIME_HI returns the shadow, never the live value.
  - Reading LO then HI therefore yields a coherent 64-bit snapshot.
- Interrupt: at every edge, `timer_irq <= EN & (mtime >= mtimecmp)`, using the pre-edge register values. Software clears it by raising `mtimecmp` or clearing EN.

## Timing
- Accepted read: `tmr_sel & tmr_rd` at edge N.
  - `tmr_rdata` and `tmr_rvalid=1` are presented after edge N and held for one cycle.
  - `tmr_rvalid` then returns to 0 and `tmr_rdata` holds its last value.
- Back-to-back reads: one result per cycle.
- Accepted write: state updates at the same edge; the new value is visible to a read issued in the next cycle.
- Simultaneous `tmr_rd` and `tmr_wr` to the same register: the write is applied, and the read returns the pre-write value.
- Interrupt latency:
  - `mtime` reaches `mtimecmp` at edge N; `timer_irq` rises after edge N+1.
  - When the compare becomes false at edge M, `timer_irq` falls after edge M+1.
- Reset asserted mid-count or mid-read: all state returns to reset values immediately (asynchronously). `tmr_rvalid` drops and any pending read is discarded. Operation resumes on the first edge after release.

## Test plan
- Reset then free run:
  - Stimulus: reset; write CTRL=0x0000_0001 (EN=1, PRESC=0); wait 10 cycles.
  - Required: LO read returns 9 or 10, consistent with the chosen cycle count; `timer_irq`=0 throughout.
- Prescaler:
  - Stimulus: CTRL=0x0000_0301 (PRESC=3).
  - Required: after 40 cycles, `mtime` has advanced by exactly 10.
  - Stimulus: rewrite CTRL mid-count.
  - Required: the next tick occurs 4 cycles later.
- Compare and interrupt:
  - Stimulus: MTIMECMP_HI=0, MTIMECMP_LO=20, EN=1, PRESC=0.
  - Required: `timer_irq` rises exactly one cycle after `mtime` == 20 and STATUS reads 1.
  - Stimulus: write MTIMECMP_LO=FFFF_FFFF.
  - Required: `timer_irq` falls within 2 cycles.
- Carry and snapshot:
  - Stimulus: MTIME_HI=0, MTIME_LO=FFFF_FFFE, EN=1; read LO then HI on consecutive cycles across the carry.
  - Required: the pair is (FFFF_FFFF, 0) or (0, 1), never (0, 0).
- Wrap and write priority:
  - Stimulus: `mtime` = 2^64-1, EN=1.
  - Required: it wraps to 0 on the next tick.
  - Stimulus: write MTIME_LO=5 on a tick cycle.
  - Required: reads back 5, not 6.
- Async reset mid-operation:
  - Stimulus: assert `rst`=0 between edges while `timer_irq`=1 and a read is pending.
  - Required: `timer_irq`, `tmr_rvalid`, `tmr_rdata` are 0 immediately; `mtimecmp` reads RESET_CMP after release.
